fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the 5-stage core.
//  Arbitrates the competing PC sources: sequential +4, branch/jump redirect, hazard
//  stall, halt/resume. Drives the IF/ID register's write and flush controls.
//  Sits between the hazard/branch logic in ID/EX and the instruction memory address port.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; first fetch address
//  FLUSH_CYC  1              bubbles injected into IF/ID per redirect (1..3)
//  CNT_W      32             width of the retired-fetch counter
// PORTS
//  clk            in   1   core clock, all state updates on rising edge
//  reset          in   1   asynchronous, active-high; forces all state to reset values
//  stall          in   1   hazard unit: hold PC and IF/ID contents this cycle
//  branch_taken   in   1   EX: redirect requested this cycle
//  branch_target  in   32  EX: redirect address, sampled when branch_taken=1
//  halt_req       in   1   ID decoded ECALL/EBREAK: stop fetching
//  resume         in   1   debug/testbench: leave HALT
//  pc             out  32  current fetch address (drives imem address)
//  fetch_valid    out  1   instruction at pc is valid for IF/ID capture
//  if_id_write    out  1   IF/ID register enable
//  if_id_flush    out  1   IF/ID register clear (insert NOP)
//  halted         out  1   FSM in HALT
//  misalign_err   out  1   sticky: redirect target with target[1:0]!=0 rejected
//  fetch_count    out  CNT_W  count of instructions accepted into IF/ID
// BEHAVIOUR
//  Reset values: pc=RESET_PC, fetch_valid=0, if_id_write=0, if_id_flush=1, halted=0,
//   misalign_err=0, fetch_count=0, state=BOOT. Reset mid-operation aborts everything.
//  States: BOOT -> RUN unconditionally after first clk edge with reset low (1 cycle, no fetch).
//   RUN: fetch_valid=1; per-cycle priority (highest first):
//    1 branch_taken & target[1:0]!=0 -> HALT, misalign_err<=1, pc unchanged, flush.
//    2 branch_taken -> pc<=branch_target, FLUSH (flush_cnt<=FLUSH_CYC-1); overrides stall.
//    3 halt_req -> HALT, pc holds, if_id_flush=1.
//    4 stall -> STALL-hold: pc holds, if_id_write=0, no count.
//    5 else pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), if_id_write=1.
//   STALL is not a separate state: stall is combinational, same-cycle effect.
//   FLUSH: if_id_flush=1, fetch_valid=0; pc advances +4 each cycle (fetching target
//    stream); after FLUSH_CYC cycles -> RUN. branch_taken in FLUSH restarts redirect
//    with new target; halt_req/stall ignored (squashed younger instrs).
//   HALT: fetch_valid=0, if_id_flush=1, pc holds, halted=1. resume=1 -> RUN next cycle,
//    fetch resumes at held pc; branch_taken ignored. misalign_err clears only on reset.
//  Outputs pc, halted, misalign_err, fetch_count are registered; fetch_valid, if_id_write,
//   if_id_flush are combinational from state + stall/branch_taken (0-cycle latency).
//  fetch_count increments when fetch_valid & if_id_write & ~if_id_flush; wraps mod 2^CNT_W.
//  Redirect latency: branch_taken at edge N -> pc=branch_target after edge N.
// STRUCTURE
//  Shared package core_pkg: state enum localparams (ST_BOOT, ST_RUN, ST_FLUSH, ST_HALT),
//   XLEN=32, NOP encoding 32'h0000_0013, PC_INC=4.
//  One sub-module: pc_next_mux (pure combinational next-PC select + alignment check);
//   FSM, flush counter and fetch counter stay in fetch_sequencer.
// TESTING
//  1 Reset, release, 5 idle cycles -> pc 0,0(BOOT),4,8,12,16; fetch_count=4.
//  2 RUN at pc=0x20, stall high 3 cycles -> pc stays 0x20, if_id_write=0, count frozen;
//    release -> pc=0x24 next edge.
//  3 branch_taken, target=0x100 while stall=1 -> pc=0x100, if_id_flush=1 for FLUSH_CYC
//    cycles, then fetch_valid=1 at pc=0x100+4*FLUSH_CYC.
//  4 branch_taken, target=0x102 -> halted=1, misalign_err=1, pc unchanged; resume -> RUN,
//    misalign_err stays 1 until reset.
//  5 halt_req at pc=0x40 -> halted=1, pc=0x40 held 10 cycles; resume -> pc=0x44 next edge.
//  6 Force pc=0xFFFF_FFFC (via branch) -> after flush pc wraps to 0x0; assert reset
//    mid-FLUSH -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, next-PC selects and ISA constants.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_SEQ      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// Combinational next-PC select plus word-alignment check of the redirect target.
module pc_next_mux
    import core_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] branch_target,
    input  pc_sel_t         pc_sel,
    output logic [XLEN-1:0] pc_next,
    output logic            target_misaligned
);

    assign target_misaligned = |branch_target[1:0];

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PC_HOLD:     pc_next = pc;
            PC_SEQ:      pc_next = pc + PC_INC;
            PC_REDIRECT: pc_next = branch_target;
            default:     pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer for the 5-stage core.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_BOOT  | one idle cycle after reset release, no fetch
// ST_RUN   | normal fetch; stall is a same-cycle hold, not a state
// ST_FLUSH | squashing IF/ID after a redirect, pc walks target stream
// ST_HALT  | fetch stopped (halt_req or misaligned redirect) until resume
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          FLUSH_CYC = 1,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      pc,
    output logic             fetch_valid,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC - 1);

    state_t     state, state_next;
    pc_sel_t    pc_sel;
    logic [31:0] pc_next;
    logic       target_misaligned;
    logic       flush_load;
    logic       set_misalign;
    logic [1:0] flush_cnt;

    pc_next_mux u_pc_next_mux (
        .pc                (pc),
        .branch_target     (branch_target),
        .pc_sel            (pc_sel),
        .pc_next           (pc_next),
        .target_misaligned (target_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            flush_cnt    <= 2'd0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (flush_load)
                flush_cnt <= FLUSH_LOAD;
            else if (state == ST_FLUSH && flush_cnt != 2'd0)
                flush_cnt <= flush_cnt - 2'd1;
            if (set_misalign)
                misalign_err <= 1'b1;
            if (fetch_valid && if_id_write && !if_id_flush)
                fetch_count <= fetch_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        pc_sel       = PC_HOLD;
        flush_load   = 1'b0;
        set_misalign = 1'b0;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (branch_taken && target_misaligned) begin
                    state_next   = ST_HALT;
                    set_misalign = 1'b1;
                end else if (branch_taken) begin
                    state_next = ST_FLUSH;
                    pc_sel     = PC_REDIRECT;
                    flush_load = 1'b1;
                end else if (halt_req) begin
                    state_next = ST_HALT;
                end else if (!stall) begin
                    pc_sel = PC_SEQ;
                end
            end
            // halt_req and stall come from instructions being squashed here
            ST_FLUSH: begin
                if (branch_taken && target_misaligned) begin
                    state_next   = ST_HALT;
                    set_misalign = 1'b1;
                end else if (branch_taken) begin
                    pc_sel     = PC_REDIRECT;
                    flush_load = 1'b1;
                end else begin
                    pc_sel = PC_SEQ;
                    if (flush_cnt == 2'd0)
                        state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume)
                    state_next = ST_RUN;
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        if (state == ST_RUN) begin
            fetch_valid = 1'b1;
            if (branch_taken || halt_req) begin
                if_id_flush = 1'b1;
            end else if (stall) begin
                if_id_flush = 1'b0;
            end else begin
                if_id_flush = 1'b0;
                if_id_write = 1'b1;
            end
        end
    end

    assign halted = (state == ST_HALT);

endmodule
